// File: rtl/card_dealer.sv
// Card dealer for a two-slot fruit-card game: timed alternating flips driven by a
// free-running Galois LFSR, with bell/hold handling and end-of-deck detection.
module card_dealer #(
    parameter int unsigned FLIP_CYCLES = 1000,
    parameter int unsigned DECK_SIZE   = 56,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       bell,
    input  logic       bell_done,
    input  logic       take,
    output logic [1:0] c1,
    output logic [1:0] c2,
    output logic [2:0] n1,
    output logic [2:0] n2,
    output logic [7:0] count,
    output logic       flip,
    output logic       game_over
);

    localparam int unsigned        TIMER_W   = $clog2(FLIP_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(FLIP_CYCLES - 1);
    localparam logic [7:0]         LAST_CARD = 8'(DECK_SIZE - 1);

    typedef enum logic [1:0] {StIdle, StDeal, StHold, StDone} state_e;

    state_e             r_state;
    state_e             w_state_d;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] w_timer_d;
    logic [15:0]        r_lfsr;
    logic [15:0]        w_lfsr_d;
    logic [7:0]         r_dealt;
    logic               r_slot;   // 0: next card goes to slot 1
    logic [1:0]         r_c1;
    logic [1:0]         r_c2;
    logic [2:0]         r_n1;
    logic [2:0]         r_n2;
    logic [7:0]         r_count;
    logic               r_flip;
    logic               w_flip_evt;
    logic               w_clear;
    logic [2:0]         w_raw;
    logic [2:0]         w_num;

    assign w_lfsr_d = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    assign w_raw    = r_lfsr[4:2];
    assign w_num    = ((w_raw >= 3'd5) ? (w_raw - 3'd5) : w_raw) + 3'd1;

    always_comb begin
        w_state_d  = r_state;
        w_timer_d  = r_timer;
        w_flip_evt = 1'b0;
        w_clear    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) w_state_d = StDeal;
            end
            StDeal: begin
                // A bell on the terminal cycle pre-empts the flip.
                if (bell) begin
                    w_state_d = StHold;
                end else if (!pause) begin
                    if (r_timer == TIMER_MAX) begin
                        w_timer_d  = '0;
                        w_flip_evt = 1'b1;
                        if (r_dealt == LAST_CARD) w_state_d = StDone;
                    end else begin
                        w_timer_d = r_timer + 1'b1;
                    end
                end
            end
            StHold: begin
                if (bell_done) begin
                    w_timer_d = '0;
                    w_clear   = take;
                    w_state_d = StDeal;
                end
            end
            StDone: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= StIdle;
            r_timer <= '0;
            r_lfsr  <= LFSR_SEED;
            r_dealt <= '0;
            r_slot  <= 1'b0;
            r_c1    <= '0;
            r_c2    <= '0;
            r_n1    <= '0;
            r_n2    <= '0;
            r_count <= '0;
            r_flip  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_timer <= w_timer_d;
            r_lfsr  <= w_lfsr_d;
            r_flip  <= w_flip_evt;
            if (w_flip_evt) begin
                r_dealt <= r_dealt + 8'd1;
                r_slot  <= ~r_slot;
                if (!r_slot) begin
                    r_c1 <= r_lfsr[1:0];
                    r_n1 <= w_num;
                end else begin
                    r_c2 <= r_lfsr[1:0];
                    r_n2 <= w_num;
                end
                if (r_count != 8'hFF) r_count <= r_count + 8'd1;
            end else if (w_clear) begin
                r_slot  <= 1'b0;
                r_c1    <= '0;
                r_c2    <= '0;
                r_n1    <= '0;
                r_n2    <= '0;
                r_count <= '0;
            end
        end
    end

    assign c1        = r_c1;
    assign c2        = r_c2;
    assign n1        = r_n1;
    assign n2        = r_n2;
    assign count     = r_count;
    assign flip      = r_flip;
    assign game_over = (r_state == StDone);

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: directed timing scenarios plus randomized
// stimulus against a pile/queue level reference model.
module tb_card_dealer;

    localparam int unsigned FC   = 4;
    localparam int unsigned DECK = 56;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0, start = 1'b0, pause = 1'b0, bell = 1'b0;
    logic       bell_done = 1'b0, take = 1'b0;
    logic [1:0] c1, c2;
    logic [2:0] n1, n2;
    logic [7:0] count;
    logic       flip, game_over;

    logic       rst6 = 1'b0, start6 = 1'b0, pause6 = 1'b0, bell6 = 1'b0;
    logic       bd6 = 1'b0, take6 = 1'b0;
    logic [1:0] c1_6, c2_6;
    logic [2:0] n1_6, n2_6;
    logic [7:0] count6;
    logic       flip6, go6;

    card_dealer #(.FLIP_CYCLES(FC), .DECK_SIZE(DECK), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .bell(bell),
        .bell_done(bell_done), .take(take), .c1(c1), .c2(c2), .n1(n1), .n2(n2),
        .count(count), .flip(flip), .game_over(game_over)
    );

    card_dealer #(.FLIP_CYCLES(FC), .DECK_SIZE(6), .LFSR_SEED(16'hACE1)) dut6 (
        .clk(clk), .rst(rst6), .start(start6), .pause(pause6), .bell(bell6),
        .bell_done(bd6), .take(take6), .c1(c1_6), .c2(c2_6), .n1(n1_6), .n2(n2_6),
        .count(count6), .flip(flip6), .game_over(go6)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [19:0] obs;
    logic [19:0] obs6;
    assign obs  = {c1, c2, n1, n2, count, flip, game_over};
    assign obs6 = {c1_6, c2_6, n1_6, n2_6, count6, flip6, go6};

    // Reference model: game phase, active-cycle accumulator, pile of dealt cards.
    int          m_phase;  // 0 idle, 1 dealing, 2 held, 3 finished
    int          m_elapsed;
    int          m_dealt;
    int          m_next;
    logic [15:0] m_lfsr;
    logic [1:0]  m_c[2];
    logic [2:0]  m_n[2];
    int          m_pile[$];
    logic        m_flip;

    task automatic model_reset();
        m_phase = 0; m_elapsed = 0; m_dealt = 0; m_next = 0; m_lfsr = 16'hACE1;
        m_c[0] = 0; m_c[1] = 0; m_n[0] = 0; m_n[1] = 0; m_pile.delete(); m_flip = 0;
    endtask

    function automatic logic [19:0] exp_vec();
        int cnt;
        cnt = (m_pile.size() > 255) ? 255 : m_pile.size();
        return {m_c[0], m_c[1], m_n[0], m_n[1], 8'(cnt), m_flip, (m_phase == 3)};
    endfunction

    task automatic tick(input logic st, input logic pa, input logic be, input logic bd,
                        input logic tk);
        int num;
        start = st; pause = pa; bell = be; bell_done = bd; take = tk;
        m_flip = 0;
        if (!rst) begin
            model_reset();
        end else begin
            case (m_phase)
                0: if (st) m_phase = 1;
                1: begin
                    if (be) m_phase = 2;
                    else if (!pa) begin
                        m_elapsed++;
                        if (m_elapsed == FC) begin
                            m_elapsed = 0;
                            num = (int'(m_lfsr[4:2]) % 5) + 1;
                            m_c[m_next] = m_lfsr[1:0];
                            m_n[m_next] = 3'(num);
                            m_pile.push_back(num);
                            m_next ^= 1;
                            m_dealt++;
                            m_flip = 1;
                            if (m_dealt == DECK) m_phase = 3;
                        end
                    end
                end
                2: if (bd) begin
                    m_elapsed = 0;
                    if (tk) begin
                        m_pile.delete();
                        m_c[0] = 0; m_c[1] = 0; m_n[0] = 0; m_n[1] = 0; m_next = 0;
                    end
                    m_phase = 1;
                end
                default: ;
            endcase
            m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        end
        @(posedge clk); #1;
        start = 0; pause = 0; bell = 0; bell_done = 0; take = 0;
    endtask

    task automatic tick6(input logic st, input logic pa, input logic be, input logic bd,
                         input logic tk);
        start6 = st; pause6 = pa; bell6 = be; bd6 = bd; take6 = tk;
        @(posedge clk); #1;
        start6 = 0; pause6 = 0; bell6 = 0; bd6 = 0; take6 = 0;
    endtask

    task automatic test_reset();
        rst = 0; tick(0, 0, 0, 0, 0); tick(0, 0, 0, 0, 0); rst = 1;
        n_vec++;
        if (obs !== 20'd0) begin
            n_err++; $display("FAIL reset_outputs got %h want 0", obs);
        end
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 1, 1, 1);
            n_vec++;
            if (obs !== 20'd0) begin
                n_err++; $display("FAIL idle_no_start got %h want 0", obs);
            end
        end
    endtask

    task automatic test_first_flips();
        logic [2:0] n1_saved;
        tick(1, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            tick(0, 0, 0, 0, 0);
            n_vec++;
            if (flip !== (i == 4)) begin
                n_err++; $display("FAIL first_flip_timing cyc %0d got %b want %b", i, flip, i == 4);
            end
        end
        n_vec++;
        if (n1 < 3'd1 || n1 > 3'd5 || n2 !== 3'd0 || count !== 8'd1) begin
            n_err++; $display("FAIL first_flip_vals got n1=%0d n2=%0d cnt=%0d want 1..5,0,1",
                              n1, n2, count);
        end
        n_vec++;
        if (obs !== exp_vec()) begin
            n_err++; $display("FAIL first_card got %h want %h", obs, exp_vec());
        end
        n1_saved = n1;
        for (int i = 1; i <= 4; i++) begin
            tick(0, 0, 0, 0, 0);
            n_vec++;
            if (flip !== (i == 4)) begin
                n_err++; $display("FAIL second_flip_timing cyc %0d got %b want %b", i, flip, i == 4);
            end
        end
        n_vec++;
        if (n2 < 3'd1 || n2 > 3'd5 || n1 !== n1_saved || count !== 8'd2) begin
            n_err++; $display("FAIL second_flip_vals got n1=%0d n2=%0d cnt=%0d want %0d,1..5,2",
                              n1, n2, count, n1_saved);
        end
        n_vec++;
        if (obs !== exp_vec()) begin
            n_err++; $display("FAIL second_card got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_pause();
        logic [19:0] saved;
        int k;
        tick(0, 0, 0, 0, 0);
        saved = obs;
        for (int i = 0; i < 10; i++) begin
            tick(0, 1, 0, 0, 0);
            n_vec++;
            if (obs !== saved) begin
                n_err++; $display("FAIL pause_frozen got %h want %h", obs, saved);
            end
        end
        k = 0;
        do begin tick(0, 0, 0, 0, 0); k++; end while (flip !== 1'b1 && k < 20);
        n_vec++;
        if (k != 3 || count !== 8'd3) begin
            n_err++; $display("FAIL pause_delay got %0d cycles cnt=%0d want 3 cycles cnt=3",
                              k, count);
        end
    endtask

    task automatic test_bell_take();
        logic [19:0] saved;
        int k;
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0);
        saved = obs;
        n_vec++;
        if (flip !== 1'b0 || count !== 8'd3) begin
            n_err++; $display("FAIL bell_beats_flip got flip=%b cnt=%0d want 0,3", flip, count);
        end
        for (int i = 0; i < 8; i++) begin
            tick(i[0], i[1], 1'b1, 0, 0);
            n_vec++;
            if (obs !== saved) begin
                n_err++; $display("FAIL hold_frozen got %h want %h", obs, saved);
            end
        end
        tick(0, 0, 0, 1, 1);
        n_vec++;
        if (obs !== 20'd0) begin
            n_err++; $display("FAIL take_clear got %h want 0", obs);
        end
        k = 0;
        do begin tick(0, 0, 0, 0, 0); k++; end while (flip !== 1'b1 && k < 20);
        n_vec++;
        if (k != 4 || n1 == 3'd0 || n2 !== 3'd0 || count !== 8'd1) begin
            n_err++; $display("FAIL take_resume got k=%0d n1=%0d n2=%0d cnt=%0d want 4,1..5,0,1",
                              k, n1, n2, count);
        end
    endtask

    task automatic test_bell_keep();
        logic [19:0] saved;
        int k;
        for (int i = 0; i < 8; i++) tick(0, 0, 0, 0, 0);
        n_vec++;
        if (count !== 8'd3) begin
            n_err++; $display("FAIL keep_prefill got %0d want 3", count);
        end
        k = $urandom_range(0, 3);
        for (int i = 0; i < k; i++) tick(0, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0);
        saved = obs;
        tick(0, 0, 0, 1, 0);
        n_vec++;
        if (obs !== saved || count !== 8'd3) begin
            n_err++; $display("FAIL keep_pile got %h want %h", obs, saved);
        end
        k = 0;
        do begin tick(0, 0, 0, 0, 0); k++; end while (flip !== 1'b1 && k < 20);
        n_vec++;
        if (k != 4 || count !== 8'd4 || obs !== exp_vec()) begin
            n_err++; $display("FAIL keep_resume got k=%0d obs=%h want 4 %h", k, obs, exp_vec());
        end
    endtask

    task automatic test_random();
        rst = 0; tick(0, 0, 0, 0, 0); rst = 1;
        for (int i = 0; i < 600; i++) begin
            tick($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 29) == 0, $urandom_range(0, 5) == 0, 1'($urandom));
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++; $display("FAIL random cyc %0d got %h want %h", i, obs, exp_vec());
            end
        end
        rst = 0; tick(0, 0, 0, 0, 0); rst = 1;
        n_vec++;
        if (obs !== 20'd0) begin
            n_err++; $display("FAIL reset_midgame got %h want 0", obs);
        end
    endtask

    task automatic test_full_deck();
        int guard;
        rst = 0; tick(0, 0, 0, 0, 0); rst = 1;
        tick(1, 0, 0, 0, 0);
        guard = 0;
        while (m_phase != 3 && guard < DECK * FC * 3) begin
            tick(0, $urandom_range(0, 7) == 0, 0, 0, 0);
            guard++;
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++; $display("FAIL deck_card cyc %0d got %h want %h", guard, obs, exp_vec());
            end
        end
        for (int i = 0; i < 20; i++) begin
            tick(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++; $display("FAIL deck_done got %h want %h", obs, exp_vec());
            end
        end
        n_vec++;
        if (game_over !== 1'b1 || count !== 8'(DECK)) begin
            n_err++; $display("FAIL deck_end got go=%b cnt=%0d want 1,%0d", game_over, count, DECK);
        end
    endtask

    task automatic test_game_over();
        logic [19:0] saved;
        int flips, guard;
        rst6 = 0; tick6(0, 0, 0, 0, 0); rst6 = 1;
        tick6(1, 0, 0, 0, 0);
        flips = 0; guard = 0;
        while (go6 !== 1'b1 && guard < 100) begin
            tick6(0, 0, 0, 0, 0);
            if (flip6 === 1'b1) flips++;
            guard++;
        end
        n_vec++;
        if (flips != 6 || flip6 !== 1'b1 || count6 !== 8'd6 || guard != 6 * FC) begin
            n_err++; $display("FAIL deck6_end got flips=%0d flip=%b cnt=%0d cyc=%0d want 6,1,6,%0d",
                              flips, flip6, count6, guard, 6 * FC);
        end
        saved = obs6 & ~20'b10;
        for (int i = 0; i < 30; i++) begin
            tick6(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            n_vec++;
            if (obs6 !== saved) begin
                n_err++; $display("FAIL done_frozen got %h want %h", obs6, saved);
            end
        end
        rst6 = 0; tick6(0, 0, 0, 0, 0); rst6 = 1;
        n_vec++;
        if (obs6 !== 20'd0) begin
            n_err++; $display("FAIL done_reset got %h want 0", obs6);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_flips();
        test_pause();
        test_bell_take();
        test_bell_keep();
        test_random();
        test_full_deck();
        test_game_over();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
